// File: rtl/ram_capture_ring.sv
// Circular waveform capture buffer: records samples after arm, freezes a
// pre/post window around a trigger and drains it through a 1-cycle-latency read port.
module ram_capture_ring #(
  parameter int unsigned P_NBITS_ADDR = 8,
  parameter int unsigned P_NBITS_DATA = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [P_NBITS_DATA-1:0] d,
  input  logic                    arm,
  input  logic                    trig,
  input  logic                    abort,
  input  logic [P_NBITS_ADDR-1:0] n_pre,
  input  logic [P_NBITS_ADDR-1:0] n_post,
  input  logic                    rd_en,
  output logic [P_NBITS_DATA-1:0] q,
  output logic                    q_valid,
  output logic                    busy,
  output logic                    done,
  output logic [P_NBITS_ADDR:0]   win_len,
  output logic [P_NBITS_ADDR-1:0] trig_addr
);

  localparam int unsigned AW    = P_NBITS_ADDR;
  localparam int unsigned CW    = P_NBITS_ADDR + 1;
  localparam int unsigned DW    = P_NBITS_DATA;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ARMED,
    S_POST,
    S_READY
  } state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] n_pre_r;
  logic [AW-1:0] n_post_r;
  logic [CW-1:0] cnt;
  logic [AW-1:0] n_post_clamp_c;
  logic          wr_en_c;
  logic          rd_issue_c;

  // ~n_pre equals D-1-n_pre, the room left for post-trigger samples
  assign n_post_clamp_c = (n_post < ~n_pre) ? n_post : ~n_pre;
  assign wr_en_c        = (state == S_FILL) || (state == S_ARMED) || (state == S_POST);
  assign rd_issue_c     = (state == S_READY) && rd_en && !abort && (cnt < win_len);

  // Sample storage, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr] <= d;
    end
  end

  // Control FSM, pointers, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      n_pre_r   <= '0;
      n_post_r  <= '0;
      cnt       <= '0;
      q         <= '0;
      q_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_len   <= '0;
      trig_addr <= '0;
    end else begin
      q_valid <= rd_issue_c;
      if (rd_issue_c) begin
        q      <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
        cnt    <= cnt + CW'(1);
      end
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm) begin
              n_pre_r  <= n_pre;
              n_post_r <= n_post_clamp_c;
              win_len  <= CW'(n_pre) + CW'(n_post_clamp_c) + CW'(1);
              cnt      <= '0;
              busy     <= 1'b1;
              state    <= (n_pre != '0) ? S_FILL : S_ARMED;
            end
          end
          S_FILL: begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(n_pre_r) - CW'(1)) begin
              state <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (trig) begin
              trig_addr <= wr_ptr;
              rd_ptr    <= wr_ptr - n_pre_r;
              cnt       <= '0;
              if (n_post_r != '0) begin
                state <= S_POST;
              end else begin
                state <= S_READY;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          S_POST: begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(n_post_r) - CW'(1)) begin
              cnt   <= '0;
              state <= S_READY;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          S_READY: begin
            // Leave once the final word is on q
            if (cnt == win_len) begin
              state <= S_IDLE;
              done  <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
